frogger_game_fsm: RTL and testbench

//  Parametrised top-level game controller for Frogger: menu, play, death, level advance, win, game over.

---
 rtl/frogger_game_fsm.sv | 125 ++++++++++++
 tb/tb_frogger_game_fsm.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/frogger_game_fsm.sv
// frogger_game_fsm: Frogger game controller tracking state, level, lives, respawn and sound triggers
module frogger_game_fsm #(
  parameter int NUM_LEVELS  = 4,
  parameter int LEVEL_W     = 4,
  parameter int LIVES       = 3,
  parameter int LIVES_W     = 2,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         dpad_input,
  input  logic               collision,
  input  logic               reached_end,
  output logic [2:0]         state,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic               win,
  output logic               lose,
  output logic               respawn,
  output logic [1:0]         soundselector,
  output logic               playsound
);
  localparam int CNT_W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LIVES_W-1:0] START_LIVES = LIVES_W'(LIVES);
  typedef enum logic [2:0] {
    MENU = 3'd0, PLAYING = 3'd1, DEAD = 3'd2, LEVELUP = 3'd3, WIN = 3'd4, GAMEOVER = 3'd5
  } state_t;
  state_t state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] dpad_prev_q;
  logic [1:0] sel_q, sel_d;
  logic win_q, win_d, lose_q, lose_d, respawn_q, respawn_d, play_q, play_d;
  logic press;
  assign press = (|dpad_input) && !(|dpad_prev_q);
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    win_d = win_q;
    lose_d = lose_q;
    respawn_d = 1'b0;
    play_d = 1'b0;
    case (state_q)
      MENU: if (press) begin
        state_d = PLAYING;
        level_d = '0;
        lives_d = START_LIVES;
        respawn_d = 1'b1;
        play_d = 1'b1;
        sel_d = 2'd0;
      end
      PLAYING: if (collision) begin
        play_d = 1'b1;
        sel_d = 2'd2;
        state_d = lives_q > LIVES_W'(1) ? DEAD : GAMEOVER;
        lives_d = lives_q > LIVES_W'(1) ? lives_q - LIVES_W'(1) : '0;
        lose_d = !(lives_q > LIVES_W'(1));
        cnt_d = CNT_LOAD;
      end else if (reached_end) begin
        play_d = 1'b1;
        sel_d = level_q < LAST_LEVEL ? 2'd1 : 2'd3;
        state_d = level_q < LAST_LEVEL ? LEVELUP : WIN;
        level_d = level_q < LAST_LEVEL ? level_q + LEVEL_W'(1) : level_q;
        win_d = !(level_q < LAST_LEVEL);
        cnt_d = CNT_LOAD;
      end
      DEAD, LEVELUP: begin
        state_d = cnt_q == '0 ? PLAYING : state_q;
        respawn_d = cnt_q == '0;
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
      end
      WIN, GAMEOVER: if (press) begin
        state_d = MENU;
        win_d = 1'b0;
        lose_d = 1'b0;
        sel_d = 2'd0;
        play_d = 1'b1;
      end
      default: begin
        state_d = MENU;
        win_d = 1'b0;
        lose_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MENU;
      level_q <= '0;
      lives_q <= START_LIVES;
      cnt_q <= '0;
      dpad_prev_q <= '0;
      sel_q <= 2'd0;
      win_q <= 1'b0;
      lose_q <= 1'b0;
      respawn_q <= 1'b0;
      play_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      cnt_q <= cnt_d;
      dpad_prev_q <= dpad_input;
      sel_q <= sel_d;
      win_q <= win_d;
      lose_q <= lose_d;
      respawn_q <= respawn_d;
      play_q <= play_d;
    end
  end
  assign state = state_q;
  assign level = level_q;
  assign lives = lives_q;
  assign win = win_q;
  assign lose = lose_q;
  assign respawn = respawn_q;
  assign soundselector = sel_q;
  assign playsound = play_q;
endmodule

// File: tb/tb_frogger_game_fsm.sv
// tb_frogger_game_fsm: directed self-checking bench for frogger_game_fsm
module tb_frogger_game_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] dpad_input = '0;
  logic collision = 1'b0;
  logic reached_end = 1'b0;
  logic [2:0] state;
  logic [3:0] level;
  logic [1:0] lives;
  logic win, lose, respawn, playsound;
  logic [1:0] soundselector;
  int checks = 0;
  int errors = 0;
  int pulses;
  frogger_game_fsm #(.NUM_LEVELS(2), .LEVEL_W(4), .LIVES(2), .LIVES_W(2), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .dpad_input(dpad_input), .collision(collision),
    .reached_end(reached_end), .state(state), .level(level), .lives(lives), .win(win),
    .lose(lose), .respawn(respawn), .soundselector(soundselector), .playsound(playsound)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst_state", state, 0);
    chk("rst_level", level, 0);
    chk("rst_lives", lives, 2);
    chk("rst_flags", {win, lose, respawn, playsound}, 0);
    chk("rst_sel", soundselector, 0);
    reset = 1'b0;
    cyc();
    dpad_input = 4'b0010;
    cyc();
    chk("t1_state", state, 1);
    chk("t1_pulses", {respawn, playsound, soundselector}, 4'b1100);
    chk("t1_lvl_lives", {level, lives}, {4'd0, 2'd2});
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      pulses += int'(respawn) + int'(playsound);
    end
    chk("t1_single_press", pulses, 0);
    chk("t1_still_play", state, 1);
    dpad_input = '0;
    collision = 1'b1;
    cyc();
    collision = 1'b0;
    chk("t2_dead", {state, lives, soundselector, playsound}, {3'd2, 2'd1, 2'd2, 1'b1});
    cyc();
    chk("t2_sound_1cyc", playsound, 0);
    cyc();
    cyc();
    chk("t2_hold", {state, respawn}, {3'd2, 1'b0});
    cyc();
    chk("t2_back", {state, respawn}, {3'd1, 1'b1});
    collision = 1'b1;
    cyc();
    collision = 1'b0;
    chk("t2_over", {state, lose, lives, soundselector, playsound}, {3'd5, 1'b1, 2'd0, 2'd2, 1'b1});
    cyc();
    chk("t2_sticky", {state, lose, playsound}, {3'd5, 1'b1, 1'b0});
    dpad_input = 4'b0001;
    cyc();
    dpad_input = '0;
    chk("go_menu", {state, lose, soundselector, playsound, lives}, {3'd0, 1'b0, 2'd0, 1'b1, 2'd0});
    collision = 1'b1;
    reached_end = 1'b1;
    cyc();
    collision = 1'b0;
    reached_end = 1'b0;
    chk("menu_ignore", {state, playsound}, {3'd0, 1'b0});
    dpad_input = 4'b1000;
    cyc();
    dpad_input = '0;
    chk("t3_start", {state, level, lives}, {3'd1, 4'd0, 2'd2});
    reached_end = 1'b1;
    cyc();
    reached_end = 1'b0;
    chk("t3_levelup", {state, level, soundselector, playsound}, {3'd3, 4'd1, 2'd1, 1'b1});
    cyc();
    cyc();
    cyc();
    chk("t3_hold", state, 3);
    cyc();
    chk("t3_back", {state, respawn, playsound}, {3'd1, 1'b1, 1'b0});
    reached_end = 1'b1;
    cyc();
    reached_end = 1'b0;
    chk("t3_win", {state, win, soundselector, playsound, level}, {3'd4, 1'b1, 2'd3, 1'b1, 4'd1});
    cyc();
    chk("t3_win_sticky", {state, win, playsound}, {3'd4, 1'b1, 1'b0});
    dpad_input = 4'b0100;
    cyc();
    dpad_input = '0;
    chk("t5_menu", {state, win, soundselector, playsound, level}, {3'd0, 1'b0, 2'd0, 1'b1, 4'd1});
    cyc();
    dpad_input = 4'b0100;
    cyc();
    dpad_input = '0;
    chk("t5_restart", {state, level, lives, respawn}, {3'd1, 4'd0, 2'd2, 1'b1});
    collision = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("t6_dead_held", {state, lives}, {3'd2, 2'd1});
    reset = 1'b1;
    #2;
    chk("t6_async_rst", {state, lives, playsound, respawn}, {3'd0, 2'd2, 1'b0, 1'b0});
    cyc();
    collision = 1'b0;
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      pulses += int'(respawn) + int'(playsound);
    end
    chk("t6_no_pulse", pulses, 0);
    chk("t6_menu", state, 0);
    dpad_input = 4'b0001;
    cyc();
    dpad_input = '0;
    collision = 1'b1;
    reached_end = 1'b1;
    cyc();
    reached_end = 1'b0;
    chk("t4_priority", {state, lives, level, soundselector}, {3'd2, 2'd1, 4'd0, 2'd2});
    cyc();
    cyc();
    cyc();
    chk("t4_held_coll", {state, lives}, {3'd2, 2'd1});
    cyc();
    collision = 1'b0;
    chk("t4_back", {state, lives, respawn}, {3'd1, 2'd1, 1'b1});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
